// File: rtl/count_sequencer.sv
// count_sequencer: control stage in front of a clearable up-counter.
// Accepts start/stop/resume requests, issues a one-cycle active-low clear,
// produces prescaled count enables and halts when the fed-back count hits
// the latched limit.
//
// Ports:
//   clock, reset              - clock, async active-high reset
//   start, stop, resume       - level-sampled control requests
//   prescale [PRE_W]          - enable period minus one (latched on start)
//   limit    [CNT_W]          - terminal count (latched on start)
//   q        [CNT_W]          - counter value fed back from the counter
//   count_enable              - one-cycle enable per prescale tick (combinational)
//   clear                     - active-low counter clear (registered)
//   done                      - high while in DONE (registered)
//   state    [3]              - current state encoding

module count_sequencer #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned PRE_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             resume,
    input  logic [PRE_W-1:0] prescale,
    input  logic [CNT_W-1:0] limit,
    input  logic [CNT_W-1:0] q,
    output logic             count_enable,
    output logic             clear,
    output logic             done,
    output logic [2:0]       state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q,    state_d;
    logic [PRE_W-1:0] pre_cnt_q,  pre_cnt_d;
    logic [PRE_W-1:0] prescale_q, prescale_d;
    logic [CNT_W-1:0] limit_q,    limit_d;
    logic             clear_q,    clear_d;
    logic             done_q,     done_d;

    logic tick;
    logic at_limit;

    assign tick     = (pre_cnt_q == prescale_q);
    assign at_limit = (q == limit_q);

    // Gating on at_limit stops a prescale-0 run from overshooting the limit.
    assign count_enable = (state_q == S_RUN) && tick && !at_limit;
    assign clear        = clear_q;
    assign done         = done_q;
    assign state        = state_q;

    // Next-state, prescale phase and latched configuration.
    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        prescale_d = prescale_q;
        limit_d    = limit_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    prescale_d = prescale;
                    limit_d    = limit;
                    state_d    = S_CLEAR;
                end
            end
            S_CLEAR: begin
                pre_cnt_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (at_limit) begin
                    state_d = S_DONE;
                end else if (stop) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    pre_cnt_d = '0;
                end else begin
                    pre_cnt_d = pre_cnt_q + PRE_W'(1);
                end
            end
            S_PAUSE: begin
                // pre_cnt holds so the prescale phase survives the pause.
                if (stop) begin
                    state_d = S_IDLE;
                end else if (resume) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (start) begin
                    prescale_d = prescale;
                    limit_d    = limit;
                    state_d    = S_CLEAR;
                end else if (stop) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered strobes follow the state being entered.
        clear_d = (state_d != S_CLEAR);
        done_d  = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pre_cnt_q  <= '0;
            prescale_q <= '0;
            limit_q    <= '0;
            clear_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            prescale_q <= prescale_d;
            limit_q    <= limit_d;
            clear_q    <= clear_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: models the downstream clearable counter, issues
// runs (directed and random), predicts the event timeline from the timing
// rules and checks it with a monitor that pops a scoreboard queue.

module tb_count_sequencer;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned PRE_W = 4;

    localparam int EV_CLR   = 0;
    localparam int EV_EN    = 1;
    localparam int EV_PAUSE = 2;
    localparam int EV_DONE  = 3;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic             clock    = 1'b0;
    logic             reset    = 1'b1;
    logic             start    = 1'b0;
    logic             stop     = 1'b0;
    logic             resume   = 1'b0;
    logic [PRE_W-1:0] prescale = '0;
    logic [CNT_W-1:0] limit    = '0;
    logic [CNT_W-1:0] q_cnt    = '0;
    logic             count_enable;
    logic             clear;
    logic             done;
    logic [2:0]       state;

    int  cyc   = 0;
    int  tests = 0;
    int  fails = 0;
    bit  mon_en = 1'b0;
    logic       prev_done  = 1'b0;
    logic [2:0] prev_state = 3'd0;
    ev_t sb_q[$];

    count_sequencer #(.CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .resume       (resume),
        .prescale     (prescale),
        .limit        (limit),
        .q            (q_cnt),
        .count_enable (count_enable),
        .clear        (clear),
        .done         (done),
        .state        (state)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Downstream 4-bit counter: synchronous active-low clear, not reset by reset.
    always @(posedge clock) begin
        if (!clear)            q_cnt <= '0;
        else if (count_enable) q_cnt <= q_cnt + CNT_W'(1);
    end

    task automatic check_ev(input int kind, input int qv);
        ev_t e;
        tests++;
        if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind=%0d cyc=%0d q=%0d, expected no event", kind, cyc, qv);
            return;
        end
        e = sb_q.pop_front();
        if (e.kind != kind || e.cyc != cyc || (e.val >= 0 && e.val != qv)) begin
            fails++;
            $display("FAIL event: got kind=%0d cyc=%0d q=%0d, expected kind=%0d cyc=%0d q=%0d",
                     kind, cyc, qv, e.kind, e.cyc, e.val);
        end
    endtask

    // Monitor: every observable event pops one scoreboard entry.
    always @(negedge clock) begin
        if (mon_en && !reset) begin
            if (!clear)                               check_ev(EV_CLR, -1);
            if (state == 3'd3 && prev_state != 3'd3)  check_ev(EV_PAUSE, -1);
            if (count_enable)                         check_ev(EV_EN, int'(q_cnt));
            if (done && !prev_done)                   check_ev(EV_DONE, int'(q_cnt));
        end
        prev_done  <= done;
        prev_state <= state;
    end

    task automatic check_val(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input int v);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    // One run: start (optionally with stop), optional single pause at RUN
    // cycle s lasting d cycles. Expected timeline from the timing rules:
    // enable j (0-based) at RUN cycle (j+1)(P+1); cycles after the pause are
    // shifted by d+1; DONE one edge after q reaches L.
    task automatic run_job(input int p, input int l, input int s, input int d, input bit with_stop);
        int  e0;
        int  r;
        int  sh;
        int  done_cyc;
        bit  paused;
        @(negedge clock);
        prescale = PRE_W'(p);
        limit    = CNT_W'(l);
        start    = 1'b1;
        stop     = with_stop;
        e0       = cyc + 1;
        sh       = (s > 0) ? d + 1 : 0;
        paused   = 1'b0;
        push_ev(EV_CLR, e0, -1);
        for (int j = 0; j < l; j++) begin
            r = (j + 1) * (p + 1);
            if (s > 0 && r > s && !paused) begin
                push_ev(EV_PAUSE, e0 + s + 1, -1);
                paused = 1'b1;
            end
            push_ev(EV_EN, e0 + r + ((s > 0 && r > s) ? sh : 0), j);
        end
        if (s > 0 && !paused) push_ev(EV_PAUSE, e0 + s + 1, -1);
        done_cyc = e0 + l * (p + 1) + 2 + sh;
        push_ev(EV_DONE, done_cyc, l);

        @(negedge clock);
        start = 1'b0;
        stop  = 1'b0;
        if (s > 0) begin
            wait_cyc(e0 + s);
            stop = 1'b1;
            @(negedge clock);
            stop = 1'b0;
            wait_cyc(e0 + s + d);
            resume = 1'b1;
            @(negedge clock);
            resume = 1'b0;
        end
        wait_cyc(done_cyc + 1);
        #1;
        check_val("pending_events", sb_q.size(), 0);
        check_val("done_state", int'(state), 4);
        check_val("final_q", int'(q_cnt), l);
        sb_q.delete();
    endtask

    task automatic go_idle();
        @(negedge clock);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        check_val("stop_to_idle", int'(state), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, l, s, d;
        // Reset values while reset is held.
        #12;
        check_val("rst_state", int'(state), 0);
        check_val("rst_clear", int'(clear), 1);
        check_val("rst_done", int'(done), 0);
        check_val("rst_en", int'(count_enable), 0);
        @(negedge clock);
        reset  = 1'b0;
        mon_en = 1'b1;

        run_job(0, 5, 0, 0, 1'b1);   // start and stop together: start wins
        run_job(3, 3, 0, 0, 1'b0);   // restarted from DONE
        go_idle();
        run_job(2, 4, 7, 10, 1'b0);  // pause after the 2nd enable, 10 cycles
        run_job(0, 0, 0, 0, 1'b0);   // limit 0: no enables
        run_job(1, 2, 0, 0, 1'b0);   // fresh run from DONE

        // Asynchronous reset in RUN with q=2; counter must keep its value.
        mon_en = 1'b0;
        @(negedge clock);
        prescale = PRE_W'(0);
        limit    = CNT_W'(9);
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 40 && q_cnt != CNT_W'(2); k++) @(negedge clock);
        check_val("q_before_reset", int'(q_cnt), 2);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_rst_state", int'(state), 0);
        check_val("async_rst_clear", int'(clear), 1);
        check_val("async_rst_done", int'(done), 0);
        check_val("async_rst_en", int'(count_enable), 0);
        repeat (3) @(negedge clock);
        check_val("q_held_in_reset", int'(q_cnt), 2);
        reset = 1'b0;
        sb_q.delete();
        @(negedge clock);
        mon_en = 1'b1;
        run_job(1, 3, 0, 0, 1'b0);   // first enable must see q cleared to 0

        // Randomized runs.
        for (int n = 0; n < 20; n++) begin
            p = int'($urandom_range(0, 3));
            l = int'($urandom_range(0, 15));
            s = 0;
            d = 0;
            if (p > 0 && l > 0 && $urandom_range(0, 1) == 1) begin
                s = int'($urandom_range(1, l * (p + 1)));
                if (s % (p + 1) == 0) s = s - 1;
                d = int'($urandom_range(1, 12));
            end
            run_job(p, l, s, d, (state == 3'd0) ? 1'($urandom_range(0, 1)) : 1'b0);
            if ($urandom_range(0, 2) == 0) go_idle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
